// File: rtl/ca4l_pkg.sv
// Shared types and response codes for the ca4l register arbiter.
// Imported by the arbiter top and its holding registers.
package ca4l_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int CA4L_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Address-channel hold entry (AW and AR share this shape).
    typedef logic [CA4L_ADDR_W-1:0] addr_entry_t;

endpackage

// File: rtl/ca4l_hold_reg.sv
// One-entry valid/ready holding register.
// Ready while empty; loads on handshake, empties when taken.
module ca4l_hold_reg
    import ca4l_pkg::*;
#(
    parameter int W = CA4L_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_take,
    output logic         o_ready,
    output logic         o_held,
    output logic [W-1:0] o_data
);

    logic         r_held;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else if (i_valid && !r_held) begin
            r_held <= 1'b1;
            r_data <= i_data;
        end else if (i_take) begin
            r_held <= 1'b0;
        end
    end

    assign o_ready = !r_held;
    assign o_held  = r_held;
    assign o_data  = r_data;

endmodule

// File: rtl/ca4l_reg_arbiter.sv
// AXI4-Lite slave fronting a single-ported PL register bank.
// Round-robin read/write arbitration, decode, one access at a time.
module ca4l_reg_arbiter
    import ca4l_pkg::*;
#(
    parameter int                ADDR_W    = CA4L_ADDR_W,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h43C0_0000,
    parameter int                NUM_REGS  = 16,
    parameter int                TIMEOUT   = 255
) (
    input  logic                       fclk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          ca4l_awaddr,
    input  logic [2:0]                 ca4l_awprot,
    input  logic                       ca4l_awvalid,
    output logic                       ca4l_awready,
    input  logic [DATA_W-1:0]          ca4l_wdata,
    input  logic [DATA_W/8-1:0]        ca4l_wstrb,
    input  logic                       ca4l_wvalid,
    output logic                       ca4l_wready,
    output logic [1:0]                 ca4l_bresp,
    output logic                       ca4l_bvalid,
    input  logic                       ca4l_bready,
    input  logic [ADDR_W-1:0]          ca4l_araddr,
    input  logic [2:0]                 ca4l_arprot,
    input  logic                       ca4l_arvalid,
    output logic                       ca4l_arready,
    output logic [DATA_W-1:0]          ca4l_rdata,
    output logic [1:0]                 ca4l_rresp,
    output logic                       ca4l_rvalid,
    input  logic                       ca4l_rready,
    output logic                       reg_req,
    output logic                       reg_we,
    output logic [$clog2(NUM_REGS)-1:0] reg_idx,
    output logic [DATA_W-1:0]          reg_wdata,
    output logic [DATA_W/8-1:0]        reg_wstrb,
    input  logic                       reg_ack,
    input  logic [DATA_W-1:0]          reg_rdata,
    input  logic                       reg_err
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_wr;
    logic                  r_we;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_req;
    logic [1:0]            r_resp;
    logic [DATA_W-1:0]     r_rdata;
    logic [15:0]           r_cnt;
    logic                  r_bvalid;
    logic                  r_rvalid;

    logic                  w_aw_held;
    logic                  w_w_held;
    logic                  w_ar_held;
    logic [ADDR_W-1:0]     w_aw_addr;
    logic [ADDR_W-1:0]     w_ar_addr;
    logic [DATA_W+STRB_W-1:0] w_w_data;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_grant;
    logic                  w_ack;
    logic                  w_tout;
    logic                  w_resp_done;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_hit;
    logic                  w_unused;

    ca4l_hold_reg #(.W(ADDR_W)) u_aw (
        .clk     (fclk),
        .rst_n   (rst_n),
        .i_valid (ca4l_awvalid),
        .i_data  (ca4l_awaddr),
        .i_take  (w_grant_wr),
        .o_ready (ca4l_awready),
        .o_held  (w_aw_held),
        .o_data  (w_aw_addr)
    );

    ca4l_hold_reg #(.W(DATA_W + STRB_W)) u_w (
        .clk     (fclk),
        .rst_n   (rst_n),
        .i_valid (ca4l_wvalid),
        .i_data  ({ca4l_wstrb, ca4l_wdata}),
        .i_take  (w_grant_wr),
        .o_ready (ca4l_wready),
        .o_held  (w_w_held),
        .o_data  (w_w_data)
    );

    ca4l_hold_reg #(.W(ADDR_W)) u_ar (
        .clk     (fclk),
        .rst_n   (rst_n),
        .i_valid (ca4l_arvalid),
        .i_data  (ca4l_araddr),
        .i_take  (w_grant_rd),
        .o_ready (ca4l_arready),
        .o_held  (w_ar_held),
        .o_data  (w_ar_addr)
    );

    assign w_grant = w_grant_wr | w_grant_rd;
    assign w_addr  = w_grant_wr ? w_aw_addr : w_ar_addr;
    assign w_hit   = w_addr[ADDR_W-1:IDX_W+2] == BASE_ADDR[ADDR_W-1:IDX_W+2];
    assign w_unused = ^{ca4l_awprot, ca4l_arprot, w_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_ack       = 1'b0;
        w_tout      = 1'b0;
        w_resp_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                // On a tie, serve the direction not taken last time.
                if (w_aw_held && w_w_held && (!w_ar_held || !r_last_wr))
                    w_grant_wr = 1'b1;
                else if (w_ar_held)
                    w_grant_rd = 1'b1;
                if (w_grant_wr || w_grant_rd)
                    w_state_nxt = w_hit ? ACCESS : RESP;
            end
            ACCESS: begin
                if (reg_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_tout      = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (r_we ? ca4l_bready : ca4l_rready) begin
                    w_resp_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_wr <= 1'b0;
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_req     <= 1'b0;
            r_resp    <= OKAY;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_wr <= w_grant_wr;
                r_we      <= w_grant_wr;
                r_idx     <= w_addr[IDX_W+1:2];
                r_cnt     <= '0;
                if (w_grant_wr) begin
                    r_wdata <= w_w_data[DATA_W-1:0];
                    r_wstrb <= w_w_data[DATA_W+:STRB_W];
                end
                if (w_hit) begin
                    r_req <= 1'b1;
                end else begin
                    r_resp   <= DECERR;
                    r_bvalid <= w_grant_wr;
                    r_rvalid <= w_grant_rd;
                    if (w_grant_rd) r_rdata <= '0;
                end
            end
            if (w_ack || w_tout) begin
                r_req    <= 1'b0;
                r_resp   <= (w_tout || reg_err) ? SLVERR : OKAY;
                r_bvalid <= r_we;
                r_rvalid <= !r_we;
                if (!r_we)
                    r_rdata <= (w_ack && !reg_err) ? reg_rdata : '0;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_resp_done) begin
                r_bvalid <= 1'b0;
                r_rvalid <= 1'b0;
            end
        end
    end

    assign ca4l_bresp  = r_resp;
    assign ca4l_bvalid = r_bvalid;
    assign ca4l_rresp  = r_resp;
    assign ca4l_rvalid = r_rvalid;
    assign ca4l_rdata  = r_rdata;
    assign reg_req     = r_req;
    assign reg_we      = r_we;
    assign reg_idx     = r_idx;
    assign reg_wdata   = r_wdata;
    assign reg_wstrb   = r_wstrb;

endmodule

// File: tb/tb_ca4l_reg_arbiter.sv
// Scoreboard bench for ca4l_reg_arbiter: directed cases plus
// randomized single transactions against a window/register model.
module tb_ca4l_reg_arbiter;

    localparam logic [31:0] BASE = 32'h43C0_0000;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ca4l_awaddr = '0;
    logic [2:0]  ca4l_awprot = '0;
    logic        ca4l_awvalid = 1'b0;
    logic        ca4l_awready;
    logic [31:0] ca4l_wdata = '0;
    logic [3:0]  ca4l_wstrb = '0;
    logic        ca4l_wvalid = 1'b0;
    logic        ca4l_wready;
    logic [1:0]  ca4l_bresp;
    logic        ca4l_bvalid;
    logic        ca4l_bready = 1'b1;
    logic [31:0] ca4l_araddr = '0;
    logic [2:0]  ca4l_arprot = '0;
    logic        ca4l_arvalid = 1'b0;
    logic        ca4l_arready;
    logic [31:0] ca4l_rdata;
    logic [1:0]  ca4l_rresp;
    logic        ca4l_rvalid;
    logic        ca4l_rready = 1'b1;
    logic        reg_req;
    logic        reg_we;
    logic [3:0]  reg_idx;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ack = 1'b0;
    logic [31:0] reg_rdata = '0;
    logic        reg_err = 1'b0;

    ca4l_reg_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .BASE_ADDR (BASE),
        .NUM_REGS  (16),
        .TIMEOUT   (8)
    ) dut (
        .fclk         (fclk),
        .rst_n        (rst_n),
        .ca4l_awaddr  (ca4l_awaddr),
        .ca4l_awprot  (ca4l_awprot),
        .ca4l_awvalid (ca4l_awvalid),
        .ca4l_awready (ca4l_awready),
        .ca4l_wdata   (ca4l_wdata),
        .ca4l_wstrb   (ca4l_wstrb),
        .ca4l_wvalid  (ca4l_wvalid),
        .ca4l_wready  (ca4l_wready),
        .ca4l_bresp   (ca4l_bresp),
        .ca4l_bvalid  (ca4l_bvalid),
        .ca4l_bready  (ca4l_bready),
        .ca4l_araddr  (ca4l_araddr),
        .ca4l_arprot  (ca4l_arprot),
        .ca4l_arvalid (ca4l_arvalid),
        .ca4l_arready (ca4l_arready),
        .ca4l_rdata   (ca4l_rdata),
        .ca4l_rresp   (ca4l_rresp),
        .ca4l_rvalid  (ca4l_rvalid),
        .ca4l_rready  (ca4l_rready),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_idx      (reg_idx),
        .reg_wdata    (reg_wdata),
        .reg_wstrb    (reg_wstrb),
        .reg_ack      (reg_ack),
        .reg_rdata    (reg_rdata),
        .reg_err      (reg_err)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    rsp_t exp_b[$];
    rsp_t exp_r[$];
    acc_t exp_acc[$];
    int   ord_q[$];

    logic [31:0] ref_mem [16];
    logic [31:0] be_mem  [16];

    int chk = 0;
    int errs = 0;
    int cyc = 0;
    int be_delay = 0;
    bit be_err = 1'b0;
    bit be_never = 1'b0;
    int ack_cyc = 0;
    int b_cyc = 0;
    int last_run = 0;

    task automatic check(input string name,
                         input logic [79:0] act,
                         input logic [79:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd64);
    endfunction

    function automatic logic [3:0] win_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) / 4;
        return off[3:0];
    endfunction

    // Expected outcome of a write, from the window rules and the register model.
    task automatic expect_write(input logic [31:0] a,
                                input logic [31:0] d,
                                input logic [3:0] s);
        rsp_t e;
        acc_t x;
        e.data = '0;
        if (!in_win(a)) begin
            e.resp = 2'b11;
        end else begin
            x.we = 1'b1; x.idx = win_idx(a); x.wdata = d; x.wstrb = s;
            exp_acc.push_back(x);
            if (be_err || be_never) begin
                e.resp = 2'b10;
            end else begin
                e.resp = 2'b00;
                ref_mem[x.idx] = apply_strb(ref_mem[x.idx], d, s);
            end
        end
        exp_b.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] a);
        rsp_t e;
        acc_t x;
        e.data = '0;
        if (!in_win(a)) begin
            e.resp = 2'b11;
        end else begin
            x.we = 1'b0; x.idx = win_idx(a); x.wdata = '0; x.wstrb = '0;
            exp_acc.push_back(x);
            if (be_err || be_never) begin
                e.resp = 2'b10;
            end else begin
                e.resp = 2'b00;
                e.data = ref_mem[x.idx];
            end
        end
        exp_r.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fclk); #1;
        end
    endtask

    task automatic send_aw(input logic [31:0] a);
        ca4l_awaddr = a; ca4l_awvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (ca4l_awready) begin
                tick(1); ca4l_awvalid = 1'b0; return;
            end
            tick(1);
        end
        ca4l_awvalid = 1'b0;
        chk++; errs++;
        $display("FAIL aw_handshake: got no awready expected awready");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        ca4l_wdata = d; ca4l_wstrb = s; ca4l_wvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (ca4l_wready) begin
                tick(1); ca4l_wvalid = 1'b0; return;
            end
            tick(1);
        end
        ca4l_wvalid = 1'b0;
        chk++; errs++;
        $display("FAIL w_handshake: got no wready expected wready");
    endtask

    task automatic send_ar(input logic [31:0] a);
        ca4l_araddr = a; ca4l_arvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (ca4l_arready) begin
                tick(1); ca4l_arvalid = 1'b0; return;
            end
            tick(1);
        end
        ca4l_arvalid = 1'b0;
        chk++; errs++;
        $display("FAIL ar_handshake: got no arready expected arready");
    endtask

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic drive_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int skew);
        fork
            begin tick(skew > 0 ? skew : 0); send_aw(a); end
            begin tick(skew < 0 ? -skew : 0); send_w(d, s); end
        join
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
            tick(1); n++;
        end
        if (n >= 300) begin
            chk++; errs++;
            $display("FAIL response_wait: got %0d b / %0d r pending expected 0",
                     exp_b.size(), exp_r.size());
            exp_b.delete(); exp_r.delete();
        end
        tick(2);
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctl"},
              {ca4l_awready, ca4l_wready, ca4l_arready, ca4l_bvalid,
               ca4l_rvalid, reg_req, reg_we, ca4l_bresp, ca4l_rresp},
              80'b111_0000_0000);
        check({name, "_dat"},
              {ca4l_rdata, reg_idx, reg_wdata, reg_wstrb}, 80'h0);
    endtask

    initial forever begin
        @(posedge fclk); cyc++;
    end

    // Response monitor and reg_req run-length tracker.
    initial begin
        rsp_t e;
        int run;
        run = 0;
        forever begin
            @(negedge fclk);
            if (reg_req) run++;
            else if (run > 0) begin last_run = run; run = 0; end
            if (ca4l_bvalid && ca4l_bready) begin
                ord_q.push_back(1); b_cyc = cyc;
                if (exp_b.size() == 0) begin
                    chk++; errs++;
                    $display("FAIL unexpected_b: got bresp %0h expected none",
                             ca4l_bresp);
                end else begin
                    e = exp_b.pop_front();
                    check("bresp", {78'h0, ca4l_bresp}, {78'h0, e.resp});
                end
            end
            if (ca4l_rvalid && ca4l_rready) begin
                ord_q.push_back(0);
                if (exp_r.size() == 0) begin
                    chk++; errs++;
                    $display("FAIL unexpected_r: got rresp %0h expected none",
                             ca4l_rresp);
                end else begin
                    e = exp_r.pop_front();
                    check("rresp_rdata", {46'h0, ca4l_rresp, ca4l_rdata},
                          {46'h0, e.resp, e.data});
                end
            end
        end
    end

    // Backend register bank with programmable ack delay / error / stall.
    initial begin
        acc_t x;
        bit   seen;
        int   cnt;
        seen = 1'b0; cnt = 0;
        forever begin
            @(posedge fclk); #1;
            reg_ack = 1'b0; reg_err = 1'b0;
            if (!rst_n || !reg_req) begin
                seen = 1'b0; cnt = 0;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_acc.size() == 0) begin
                        chk++; errs++;
                        $display("FAIL unexpected_req: got idx %0d expected none",
                                 reg_idx);
                    end else begin
                        x = exp_acc.pop_front();
                        check("access",
                              {39'h0, reg_we, reg_idx,
                               reg_we ? reg_wdata : 32'h0,
                               reg_we ? reg_wstrb : 4'h0},
                              {39'h0, x.we, x.idx, x.wdata, x.wstrb});
                    end
                end
                if (!be_never) begin
                    if (cnt == be_delay) begin
                        reg_ack = 1'b1; reg_err = be_err; ack_cyc = cyc;
                        reg_rdata = be_err ? $urandom : be_mem[reg_idx];
                        if (reg_we && !be_err)
                            be_mem[reg_idx] = apply_strb(be_mem[reg_idx],
                                                         reg_wdata, reg_wstrb);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0; be_mem[i] = '0;
        end
        #2;
        check_reset("reset");
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Ties from reset: write first, then alternate.
        be_delay = 0;
        expect_write(BASE + 32'h0, 32'h1111_0001, 4'hF);
        expect_read(BASE + 32'h4);
        expect_write(BASE + 32'h8, 32'h2222_0002, 4'hF);
        expect_read(BASE + 32'hC);
        ord_q.delete();
        fork
            begin
                drive_write(BASE + 32'h0, 32'h1111_0001, 4'hF, 0);
                drive_write(BASE + 32'h8, 32'h2222_0002, 4'hF, 0);
            end
            begin
                send_ar(BASE + 32'h4);
                send_ar(BASE + 32'hC);
            end
        join
        wait_idle();
        check("tie_count", 80'(ord_q.size() >= 3), 80'h1);
        if (ord_q.size() >= 3)
            check("tie_order", {ord_q[0][0], ord_q[1][0], ord_q[2][0]}, 80'b101);

        // Single write, AW and W together, ack after 3 cycles.
        be_delay = 3;
        expect_write(BASE + 32'h8, 32'hA5A5_0001, 4'hF);
        drive_write(BASE + 32'h8, 32'hA5A5_0001, 4'hF, 0);
        wait_idle();
        check("bvalid_after_ack", 80'(b_cyc - ack_cyc), 80'h1);

        // W leads AW by two cycles: no access before AW.
        expect_write(BASE + 32'h8, 32'h5A5A_0002, 4'h3);
        send_w(32'h5A5A_0002, 4'h3);
        for (int i = 0; i < 2; i++) begin
            check("no_req_before_aw", {79'h0, reg_req}, 80'h0);
            tick(1);
        end
        send_aw(BASE + 32'h8);
        wait_idle();

        // Read held across four cycles of rready low.
        be_delay = 1;
        ref_mem[15] = 32'h1234_5678; be_mem[15] = 32'h1234_5678;
        ca4l_rready = 1'b0;
        expect_read(BASE + 32'h3C);
        send_ar(BASE + 32'h3C);
        for (int n = 0; n < 50 && !ca4l_rvalid; n++) tick(1);
        for (int i = 0; i < 4; i++) begin
            check("rvalid_hold", {45'h0, ca4l_rvalid, ca4l_rresp, ca4l_rdata},
                  {45'h0, 1'b1, 2'b00, 32'h1234_5678});
            tick(1);
        end
        ca4l_rready = 1'b1;
        wait_idle();

        // Decode misses.
        expect_read(32'h43D0_0000);
        send_ar(32'h43D0_0000);
        wait_idle();
        expect_write(32'h43D0_0000, 32'hDEAD_BEEF, 4'hF);
        drive_write(32'h43D0_0000, 32'hDEAD_BEEF, 4'hF, -1);
        wait_idle();

        // Stalled backend: timeout after exactly 8 request cycles.
        be_never = 1'b1;
        expect_read(BASE + 32'h10);
        send_ar(BASE + 32'h10);
        wait_idle();
        check("timeout_len", 80'(last_run), 80'd8);

        // Backend error on write and read.
        be_never = 1'b0; be_err = 1'b1; be_delay = 2;
        expect_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
        drive_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 1);
        wait_idle();
        expect_read(BASE + 32'h14);
        send_ar(BASE + 32'h14);
        wait_idle();
        be_err = 1'b0;

        // Reset during an access: abandoned, no response.
        be_never = 1'b1;
        begin
            acc_t x;
            x.we = 1'b1; x.idx = 4'd5; x.wdata = 32'hCAFE_0005; x.wstrb = 4'hF;
            exp_acc.push_back(x);
        end
        drive_write(BASE + 32'h14, 32'hCAFE_0005, 4'hF, 0);
        for (int n = 0; n < 50 && !reg_req; n++) tick(1);
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        tick(2);
        rst_n = 1'b1;
        be_never = 1'b0;
        tick(10);
        check("reset_acc_left", 80'(exp_acc.size()), 80'h0);

        // Randomized single transactions.
        for (int t = 0; t < 40; t++) begin
            be_delay = $urandom_range(0, 3);
            be_err = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if (in_win(a)) a = a ^ 32'h0010_0000;
            end else begin
                a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                expect_write(a, d, s);
                drive_write(a, d, s, $urandom_range(0, 4) - 2);
            end else begin
                expect_read(a);
                send_ar(a);
            end
            wait_idle();
        end
        be_err = 1'b0;
        check("acc_left", 80'(exp_acc.size()), 80'h0);

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
